// File: rtl/msk_sym_sync.sv
`default_nettype none
// ============================================================================
// msk_sym_sync : early/late gate symbol synchroniser for an MSK matched filter.
//                Optional MSK_SYM_SOFT_EN drives soft_out with the on-time sample.
// Revision     : 1.0  initial release
// ============================================================================
module msk_sym_sync #(
    parameter int WI     = 16,
    parameter int SPS    = 20,
    parameter int ELD    = 2,
    parameter int NAVG   = 8,
    parameter int THRESH = 4096,
    parameter int LOCK_N = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic signed [WI-1:0] din,
    input  logic                 din_val,
    output logic                 bit_out,
    output logic                 bit_val,
    output logic signed [WI-1:0] soft_out,
    output logic                 adj_adv,
    output logic                 adj_ret,
    output logic                 lock
);

    localparam int CW    = $clog2(SPS + 1);
    localparam int AW    = WI + 1 + $clog2(NAVG);
    localparam int SW    = $clog2(NAVG + 1);
    localparam int LW    = $clog2(LOCK_N + 1);
    localparam int c_ctr = SPS / 2;

    localparam logic [CW-1:0]        c_early = CW'(c_ctr - ELD);
    localparam logic [CW-1:0]        c_ontim = CW'(c_ctr);
    localparam logic [CW-1:0]        c_late  = CW'(c_ctr + ELD);
    localparam logic signed [AW-1:0] c_thr   = AW'(THRESH);

    generate
        if ((c_ctr - ELD) < 1 || (c_ctr + ELD) > (SPS - 3)) begin : g_bad_cfg
            $error("msk_sym_sync: early/late gates fall outside the symbol period");
        end
    endgenerate

    // Magnitude in WI+1 bits so the most negative input does not overflow.
    function automatic logic signed [WI:0] f_abs(input logic signed [WI-1:0] x);
        logic signed [WI:0] xe;
        xe = {x[WI-1], x};
        return xe[WI] ? -xe : xe;
    endfunction

    logic [CW-1:0]        r_cnt;
    logic [SW-1:0]        r_sym;
    logic [LW-1:0]        r_lock_cnt;
    logic signed [AW-1:0] r_acc;
    logic signed [WI:0]   r_early_abs;
    logic                 r_pend_adv, r_pend_ret;
    logic                 r_bit, r_bit_val, r_adj_adv, r_adj_ret, r_lock;

    logic [CW-1:0]        w_term;
    logic                 w_wrap, w_cap_e, w_cap_o, w_cap_l, w_eval, w_gt, w_lt;
    logic signed [WI:0]   w_abs_din, w_err;
    logic signed [AW-1:0] w_acc_sum;

    // A pending correction moves the wrap point of the period in progress.
    always_comb begin
        w_term = CW'(SPS - 1);
        if (r_pend_adv)
            w_term = CW'(SPS - 2);
        else if (r_pend_ret)
            w_term = CW'(SPS);
    end

    assign w_wrap    = din_val && (r_cnt == w_term);
    assign w_cap_e   = din_val && (r_cnt == c_early);
    assign w_cap_o   = din_val && (r_cnt == c_ontim);
    assign w_cap_l   = din_val && (r_cnt == c_late);
    assign w_eval    = w_cap_l && (r_sym == SW'(NAVG - 1));
    assign w_abs_din = f_abs(din);
    assign w_err     = r_early_abs - w_abs_din;
    assign w_acc_sum = r_acc + {{(AW-WI-1){w_err[WI]}}, w_err};
    assign w_gt      = w_acc_sum > c_thr;
    assign w_lt      = w_acc_sum < -c_thr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_sym       <= '0;
            r_lock_cnt  <= '0;
            r_acc       <= '0;
            r_early_abs <= '0;
            r_pend_adv  <= 1'b0;
            r_pend_ret  <= 1'b0;
            r_bit       <= 1'b0;
            r_bit_val   <= 1'b0;
            r_adj_adv   <= 1'b0;
            r_adj_ret   <= 1'b0;
            r_lock      <= 1'b0;
        end else begin
            r_bit_val <= 1'b0;
            r_adj_adv <= 1'b0;
            r_adj_ret <= 1'b0;
            r_lock    <= (r_lock_cnt == LW'(LOCK_N));

            if (din_val)
                r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;

            if (w_cap_e)
                r_early_abs <= w_abs_din;

            if (w_cap_o) begin
                r_bit     <= ~din[WI-1];
                r_bit_val <= 1'b1;
            end

            if (w_cap_l) begin
                if (w_eval) begin
                    r_acc      <= '0;
                    r_sym      <= '0;
                    r_pend_adv <= w_gt;
                    r_pend_ret <= w_lt;
                    if (w_gt || w_lt)
                        r_lock_cnt <= '0;
                    else if (r_lock_cnt != LW'(LOCK_N))
                        r_lock_cnt <= r_lock_cnt + 1'b1;
                end else begin
                    r_acc <= w_acc_sum;
                    r_sym <= r_sym + 1'b1;
                end
            end

            // Late gate always precedes the earliest wrap, so these never collide.
            if (w_wrap) begin
                r_adj_adv  <= r_pend_adv;
                r_adj_ret  <= r_pend_ret;
                r_pend_adv <= 1'b0;
                r_pend_ret <= 1'b0;
            end
        end
    end

`ifdef MSK_SYM_SOFT_EN
    logic signed [WI-1:0] r_soft;

    always_ff @(posedge clk) begin
        if (rst)
            r_soft <= '0;
        else if (w_cap_o)
            r_soft <= din;
    end

    assign soft_out = r_soft;
`else
    assign soft_out = '0;
`endif

    assign bit_out = r_bit;
    assign bit_val = r_bit_val;
    assign adj_adv = r_adj_adv;
    assign adj_ret = r_adj_ret;
    assign lock    = r_lock;

endmodule
`default_nettype wire
